// File: rtl/fx_div_pkg.sv
// Shared constants and pipeline stage record for the signed fixed-latency divider.
// The quotient register doubles as the numerator shift register during division.
package fx_div_pkg;

  localparam int DIVIDEND_W = 48;
  localparam int DIVISOR_W  = 32;
  localparam int FRAC_W     = 16;
  localparam int LATENCY    = 16;
  localparam int DOUT_W     = DIVIDEND_W + FRAC_W;

  // 48 integer bits plus 15 fractional bits of magnitude
  localparam int QUOT_W         = DIVIDEND_W + FRAC_W - 1;
  localparam int TOTAL_ITER     = QUOT_W;
  localparam int ITER_PER_STAGE = (TOTAL_ITER + LATENCY - 1) / LATENCY;
  localparam int REM_W          = DIVISOR_W + 1;

  typedef struct packed {
    logic                 valid;
    logic                 sign;
    logic [REM_W-1:0]     rem;
    logic [DIVISOR_W-1:0] dmag;
    logic [QUOT_W-1:0]    quot;
  } stage_t;

endpackage

// File: rtl/fx_div_stage.sv
// One pipeline stage: up to ITER_PER_STAGE restoring shift-subtract steps, then a register.
// Numerator bits leave the top of quot while quotient bits enter at the bottom.
module fx_div_stage
  import fx_div_pkg::*;
#(
  parameter int STAGE_IDX = 0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   en,
  input  stage_t src,
  output stage_t dst
);

  stage_t           stage_reg;
  stage_t           stage_next;
  logic [REM_W-1:0] trial;

  always_comb begin
    stage_next = src;
    trial      = '0;
    for (int i = 0; i < ITER_PER_STAGE; i++) begin
      // The final stage may have fewer than ITER_PER_STAGE steps left to do
      if (STAGE_IDX * ITER_PER_STAGE + i < TOTAL_ITER) begin
        trial           = {stage_next.rem[REM_W-2:0], stage_next.quot[QUOT_W-1]};
        stage_next.quot = {stage_next.quot[QUOT_W-2:0], 1'b0};
        if (trial >= {1'b0, stage_next.dmag}) begin
          stage_next.rem     = trial - {1'b0, stage_next.dmag};
          stage_next.quot[0] = 1'b1;
        end else begin
          stage_next.rem = trial;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_reg <= '0;
    end else if (en) begin
      stage_reg <= stage_next;
    end
  end

  assign dst = stage_reg;

endmodule

// File: rtl/fx_div_core.sv
// Signed pipelined divider: sign/magnitude split, LATENCY shift-subtract stages,
// sign reapplied on the way out. One shared enable freezes the whole pipe on back-pressure.
module fx_div_core
  import fx_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_axis_divisor_tvalid,
  output logic                  s_axis_divisor_tready,
  input  logic [DIVISOR_W-1:0]  s_axis_divisor_tdata,
  input  logic                  s_axis_dividend_tvalid,
  output logic                  s_axis_dividend_tready,
  input  logic [DIVIDEND_W-1:0] s_axis_dividend_tdata,
  output logic                  m_axis_dout_tvalid,
  input  logic                  m_axis_dout_tready,
  output logic [DOUT_W-1:0]     m_axis_dout_tdata
);

  stage_t                pipe [0:LATENCY];
  stage_t                last;
  logic                  en;
  logic                  fire;
  logic [DIVIDEND_W-1:0] n_mag;
  logic [DIVISOR_W-1:0]  d_mag;
  logic [DIVIDEND_W-1:0] q_mag;
  logic [FRAC_W-1:0]     f_mag;
  logic [DIVIDEND_W-1:0] quotient;
  logic [FRAC_W-1:0]     fraction;

  assign last = pipe[LATENCY];
  assign en   = !last.valid || m_axis_dout_tready;

  assign s_axis_dividend_tready = en && rst_n;
  assign s_axis_divisor_tready  = en && rst_n;
  assign fire = s_axis_dividend_tvalid && s_axis_divisor_tvalid && en && rst_n;

  // -2^47 and -2^31 negate to themselves, which read correctly as unsigned magnitudes
  assign n_mag = s_axis_dividend_tdata[DIVIDEND_W-1] ? -s_axis_dividend_tdata
                                                     : s_axis_dividend_tdata;
  assign d_mag = s_axis_divisor_tdata[DIVISOR_W-1] ? -s_axis_divisor_tdata
                                                   : s_axis_divisor_tdata;

  always_comb begin
    pipe[0]       = '0;
    pipe[0].valid = fire;
    pipe[0].sign  = s_axis_dividend_tdata[DIVIDEND_W-1] ^ s_axis_divisor_tdata[DIVISOR_W-1];
    pipe[0].dmag  = d_mag;
    pipe[0].quot  = {n_mag, {(FRAC_W-1){1'b0}}};
  end

  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
      fx_div_stage #(
        .STAGE_IDX(gi)
      ) u_stage (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .src  (pipe[gi]),
        .dst  (pipe[gi+1])
      );
    end
  endgenerate

  always_comb begin
    q_mag    = last.quot[QUOT_W-1:FRAC_W-1];
    f_mag    = {1'b0, last.quot[FRAC_W-2:0]};
    quotient = last.sign ? -q_mag : q_mag;
    fraction = last.sign ? -f_mag : f_mag;
  end

  // A zero divisor would otherwise yield an all-ones magnitude
  assign m_axis_dout_tdata  = (last.dmag == '0) ? '0 : {quotient, fraction};
  assign m_axis_dout_tvalid = last.valid;

endmodule

// File: tb/tb_fx_div_core.sv
// Randomized self-checking bench for fx_div_core: scoreboard of expected results
// computed with plain signed arithmetic, checked with per-op latency on every output transfer.
module tb_fx_div_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dvs_valid, dvs_ready;
  logic [31:0] dvs_data;
  logic        dvd_valid, dvd_ready;
  logic [47:0] dvd_data;
  logic        out_valid, out_ready;
  logic [63:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stalls = 0;
  int accepts = 0;
  int pops = 0;
  int mode = 0;
  int stall_left = 0;
  bit stall_done = 1'b0;

  typedef struct {
    logic [63:0] exp;
    int          cyc;
    int          st;
  } entry_t;
  entry_t sb[$];

  always #5 clk = ~clk;

  fx_div_core dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .s_axis_divisor_tvalid (dvs_valid),
    .s_axis_divisor_tready (dvs_ready),
    .s_axis_divisor_tdata  (dvs_data),
    .s_axis_dividend_tvalid(dvd_valid),
    .s_axis_dividend_tready(dvd_ready),
    .s_axis_dividend_tdata (dvd_data),
    .m_axis_dout_tvalid    (out_valid),
    .m_axis_dout_tready    (out_ready),
    .m_axis_dout_tdata     (out_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Quotient truncated toward zero, fraction = trunc(|rem| * 2^15 / |d|) carrying the quotient's sign
  function automatic logic [63:0] model(input logic [47:0] a, input logic [31:0] b);
    longint n, d, q, r, ar, ad, f;
    logic [47:0] q48;
    logic [15:0] f16;
    n = longint'($signed(a));
    d = longint'($signed(b));
    if (d == 0) return 64'd0;
    q  = n / d;
    r  = n % d;
    ar = (r < 0) ? -r : r;
    ad = (d < 0) ? -d : d;
    f  = (ar <<< 15) / ad;
    if ((n < 0) != (d < 0)) f = -f;
    q48 = q[47:0];
    f16 = f[15:0];
    return {q48, f16};
  endfunction

  // Monitor: everything sampled on the falling edge, away from the active edge
  logic        prev_hold = 1'b0;
  logic        prev_rst_low = 1'b0;
  logic [63:0] prev_data = '0;

  always @(negedge clk) begin
    entry_t e;
    logic   exp_rdy;
    cyc++;
    exp_rdy = rst_n && (!out_valid || out_ready);
    chk("dividend_tready", {63'd0, dvd_ready}, {63'd0, exp_rdy});
    chk("divisor_tready", {63'd0, dvs_ready}, {63'd0, exp_rdy});
    if (!rst_n) begin
      if (prev_rst_low) chk("reset_tvalid", {63'd0, out_valid}, 64'd0);
      sb.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("held_tvalid", {63'd0, out_valid}, 64'd1);
        chk("held_tdata", out_data, prev_data);
      end
      if (dvd_valid && dvs_valid && dvd_ready && dvs_ready) begin
        e.exp = model(dvd_data, dvs_data);
        e.cyc = cyc;
        e.st  = stalls;
        sb.push_back(e);
        accepts++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", out_data, 64'd0);
          errors += (out_data === 64'd0) ? 1 : 0;
        end else begin
          e = sb.pop_front();
          pops++;
          chk("result_data", out_data, e.exp);
          chk("result_latency", 64'(cyc), 64'(e.cyc + 16 + (stalls - e.st)));
          $display("result %0d: data=%h expected=%h", pops, out_data, e.exp);
        end
      end
      if (out_valid && !out_ready) stalls++;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
    prev_rst_low = !rst_n;
  end

  // Downstream ready: 0 = always ready, 1 = random, 2 = one 5-cycle stall on first result
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (mode != 2) stall_done = 1'b0;
      case (mode)
        1: out_ready = ($urandom_range(0, 9) < 7);
        2: begin
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else if (out_valid && !stall_done) begin
            out_ready  = 1'b0;
            stall_left = 4;
            stall_done = 1'b1;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input logic [47:0] a, input logic [31:0] b, input bit rnd);
    bit acc = 1'b0;
    dvd_data = a;
    dvs_data = b;
    for (int t = 0; t < 300; t++) begin
      dvd_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      dvs_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      acc = dvd_valid && dvs_valid && dvd_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && sb.size() != 0; t++) @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_divisor();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0:       v = 32'd0;
      1, 2, 3: v = 32'($signed($urandom_range(0, 40)) - 20);
      4, 5:    v = $urandom & 32'h0000_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  function automatic logic [47:0] rand_dividend();
    logic [63:0] w;
    w = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       return 48'h8000_0000_0000;
      1:       return 48'(signed'(w[7:0]));
      2:       return 48'(signed'(w[31:0]));
      default: return w[47:0];
    endcase
  endfunction

  initial begin
    int acc_before;
    rst_n     = 1'b0;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    dvd_data  = '0;
    dvs_data  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_ready", {62'd0, dvd_ready, dvs_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", {62'd0, dvd_ready, dvs_ready}, 64'd3);
    @(posedge clk);
    #1;

    chk("model_big", model(48'h3_0000_0000, 32'h2_0000), 64'h0000_0001_8000_0000);
    chk("model_p7_p2", model(48'd7, 32'd2), 64'h0000_0000_0003_4000);
    chk("model_n7_p2", model(48'hFFFF_FFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFD_C000);
    chk("model_p7_n2", model(48'd7, 32'hFFFF_FFFE), 64'hFFFF_FFFF_FFFD_C000);
    chk("model_n7_n2", model(48'hFFFF_FFFF_FFF9, 32'hFFFF_FFFE), 64'h0000_0000_0003_4000);
    chk("model_div0", model(48'd12345, 32'd0), 64'd0);
    chk("model_ovf", model(48'h8000_0000_0000, 32'hFFFF_FFFF), 64'h8000_0000_0000_0000);
    chk("model_1_3", model(48'd1, 32'd3), 64'h0000_0000_0000_2AAA);

    send(48'h3_0000_0000, 32'h2_0000, 1'b0);
    send(48'd7, 32'd2, 1'b0);
    send(48'hFFFF_FFFF_FFF9, 32'd2, 1'b0);
    send(48'd7, 32'hFFFF_FFFE, 1'b0);
    send(48'hFFFF_FFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
    send(48'd12345, 32'd0, 1'b0);
    send(48'h8000_0000_0000, 32'hFFFF_FFFF, 1'b0);
    send(48'd1, 32'd3, 1'b0);
    drain();

    mode = 2;
    acc_before = pops;
    for (int i = 0; i < 20; i++) send(rand_dividend(), rand_divisor(), 1'b0);
    drain();
    chk("backpressure_count", 64'(pops - acc_before), 64'd20);
    chk("backpressure_stalled", {63'd0, stall_done}, 64'd1);
    mode = 0;
    @(posedge clk);
    #1;

    acc_before = accepts;
    dvd_data  = 48'd100;
    dvs_data  = 32'd7;
    dvd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("dividend_only_none", 64'(accepts - acc_before), 64'd0);
    dvs_valid = 1'b1;
    @(posedge clk);
    #1;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    @(negedge clk);
    chk("dividend_only_one", 64'(accepts - acc_before), 64'd1);
    drain();

    for (int i = 0; i < 3; i++) send(rand_dividend(), rand_divisor(), 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    mode = 1;
    for (int i = 0; i < 200; i++) send(rand_dividend(), rand_divisor(), 1'b1);
    drain();
    mode = 0;
    repeat (20) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
